adding_machine_loader: RTL and testbench
========================================

// Module: adding_machine_loader
// PURPOSE
//  Writer for the adding machine's word memory: accepts a burst of N 32-bit words on a
//  valid/ready stream and writes them to consecutive word addresses starting at 0.
//  Sits between a host/test source and the adding-machine RAM write port; the adding
//  machine later reads the same addresses (index bits [31:2]) in the same order.
// PARAMETERS
//  ADDR_W   30   word-index width; mem_addr = {index, 2'b00} zero-extended to 32 bits
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-low; 0 clears all state immediately
//  start      in   1       begin a load burst (sampled in IDLE only)
//  count      in   ADDR_W  number of words in the burst (sampled with start)
//  in_valid   in   1       source has a word on in_data
//  in_data    in   32      word to store
//  in_ready   out  1       loader accepts in_data this cycle
//  mem_we     out  1       memory write enable (registered)
//  mem_addr   out  32      memory byte address, [1:0] always 2'b00 (registered)
//  mem_wdata  out  32      memory write data (registered)
//  busy       out  1       1 in LOAD or DONE
//  done       out  1       one-cycle pulse: burst complete
//  sum        out  32      running sum of accepted words (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; in_ready, mem_we, busy, done = 0;
//    mem_addr, mem_wdata, sum, index, remaining = 0.
//  - States: IDLE, LOAD, DONE. in_ready = (state==LOAD); busy = (state!=IDLE).
//  - IDLE: start && count!=0 -> LOAD; index<=0, remaining<=count, sum<=0.
//    start && count==0 -> DONE (no writes, done pulses next cycle). Else stay.
//  - LOAD: accept = in_valid && in_ready. On accept, next cycle: mem_we=1,
//    mem_addr={index,2'b00}, mem_wdata=in_data; index<=index+1 (mod 2^ADDR_W);
//    remaining<=remaining-1. Accept with remaining==1 -> DONE.
//    No accept -> mem_we=0 next cycle, mem_addr/mem_wdata hold, index holds.
//  - DONE: done=1 for exactly this cycle (coincides with mem_we of the last word);
//    -> IDLE unconditionally.
//  - Latency: in_data accepted at edge k appears on mem_* during cycle k+1.
//    Back-to-back accepts give one write per cycle, no bubbles.
//  - start while busy is ignored; count sampled only with start in IDLE.
//  - Index wrap: count==2^ADDR_W-1 writes addresses 0..(2^ADDR_W-2)*4; index
//    wraps to 0 mod 2^ADDR_W, never exceeding ADDR_W bits.
//  - Sum: 32-bit, wraps mod 2^32, no carry out; updated on each accept.
//  - Reset mid-burst: outputs clear the instant reset falls; the partial burst
//    is abandoned; done does not pulse; writes already issued stay in memory.
//  - in_valid in IDLE/DONE is ignored (in_ready=0, no write).
// CONFIGURATION
//  CHECKSUM_EN defined: sum is the running mod-2^32 sum of accepted words,
//    cleared on start, held after DONE until the next start or reset. Equals the
//    adding machine's final result over the same words.
//  CHECKSUM_EN undefined: no adder and no sum register; sum is tied to 32'd0.
// TESTING
//  1 reset low mid-LOAD after 2 of 4 words -> in_ready/mem_we/busy=0 at once,
//    done never pulses, next start begins again at mem_addr 0.
//  2 start,count=3; in_valid held 1 with 5,7,9 -> mem_we cycles k+1..k+3 at
//    addr 0,4,8 data 5,7,9; done=1 in 3rd write cycle; sum=21 (CHECKSUM_EN).
//  3 count=2, in_valid gaps (1,0,0,1) -> exactly 2 writes, mem_we low in gap
//    cycles, addr 0 then 4; done one cycle after the 2nd accept.
//  4 start,count=0 -> no mem_we, busy=1 one cycle, done=1 one cycle, back to IDLE.
//  5 start pulsed during LOAD with count=9 -> ignored; burst ends after original N.
//  6 words 32'hFFFF_FFFF,32'h2 with CHECKSUM_EN -> sum=32'h1; without it sum=0.

Source files
------------

// File: rtl/adding_machine_loader.sv
// ----------------------------------------------------------------------------
// adding_machine_loader
//   Writes a burst of N 32-bit words from a valid/ready stream into the adding
//   machine's word memory at consecutive word addresses starting at 0.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   begin a burst (honoured in IDLE only)
//   count      in   number of words in the burst (sampled with start)
//   in_valid   in   source presents in_data
//   in_data    in   word to store
//   in_ready   out  loader accepts in_data this cycle (high in LOAD)
//   mem_we     out  registered memory write enable
//   mem_addr   out  registered byte address {index, 2'b00}
//   mem_wdata  out  registered write data
//   busy       out  high in LOAD or DONE
//   done       out  one-cycle pulse when the burst completes
//   sum        out  running mod-2^32 sum of accepted words
//
// Configuration
//   CHECKSUM_EN  defined: sum register and adder are built.
//                undefined: sum is tied to zero.
// ----------------------------------------------------------------------------
module adding_machine_loader #(
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] remaining;
    logic              accept;
    logic              launch;

    assign accept = in_valid && in_ready;
    assign launch = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && remaining == ADDR_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // DONE lasts one cycle, so done doubles as its state decode;
                // it lines up with mem_we of the final word.
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index     <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (launch) begin
                index     <= '0;
                remaining <= count;
            end
            if (accept) begin
                mem_we    <= 1'b1;
                mem_addr  <= 32'({index, 2'b00});
                mem_wdata <= in_data;
                index     <= index + ADDR_W'(1);
                remaining <= remaining - ADDR_W'(1);
            end
        end
    end

`ifdef CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (launch) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + in_data;
        end
    end

    assign sum = sum_q;
`else
    assign sum = '0;
`endif

endmodule

// File: tb/tb_adding_machine_loader.sv
module tb_adding_machine_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [29:0] count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [31:0] sum;

    int errors = 0;
    int checks = 0;

    adding_machine_loader #(.ADDR_W(30)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    // Reference model: burst bookkeeping in words, not in FSM encodings.
    bit          m_loading;   // a burst is in progress, words still owed
    bit          m_finish;    // completion cycle
    int unsigned m_left;      // words still to accept
    logic [29:0] m_idx;       // next word index
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] m_sum;
    int          done_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".in_ready"}, 32'(in_ready), 32'(m_loading));
        chk({ctx, ".busy"},     32'(busy),     32'(m_loading | m_finish));
        chk({ctx, ".done"},     32'(done),     32'(m_finish));
        chk({ctx, ".mem_we"},   32'(mem_we),   32'(m_we));
        chk({ctx, ".mem_addr"}, mem_addr,      m_addr);
        chk({ctx, ".wdata"},    mem_wdata,     m_data);
        chk({ctx, ".sum"},      sum,           m_sum);
        if (done) done_pulses++;
    endtask

    task automatic model_clear();
        m_loading = 0; m_finish = 0; m_left = 0; m_idx = '0;
        m_we = 0; m_addr = '0; m_data = '0; m_sum = '0;
    endtask

    // Apply inputs for one cycle, advance the model, then check after the edge.
    task automatic cyc(input bit st, input logic [29:0] cnt, input bit v, input logic [31:0] d);
        bit nl;
        bit nf;
        start = st; count = cnt; in_valid = v; in_data = d;
        nl = m_loading;
        nf = 0;
        m_we = 0;
        if (!m_loading && !m_finish && st) begin
            if (cnt == 0) nf = 1;
            else begin
                nl = 1; m_left = cnt; m_idx = '0;
            end
`ifdef CHECKSUM_EN
            m_sum = '0;
`endif
        end
        if (m_loading && v) begin
            m_we   = 1;
            m_addr = {m_idx, 2'b00};
            m_data = d;
            m_idx  = m_idx + 30'd1;
            m_left = m_left - 1;
`ifdef CHECKSUM_EN
            m_sum  = m_sum + d;
`endif
            if (m_left == 0) begin
                nl = 0; nf = 1;
            end
        end
        m_loading = nl;
        m_finish  = nf;
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_clear();
        check_all("rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int guard;
        reset = 1'b0; start = 0; count = '0; in_valid = 0; in_data = '0;
        model_clear();
        done_pulses = 0;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back burst of three words.
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 5);
        cyc(0, 0, 1, 7);
        cyc(0, 0, 1, 9);
        chk("t2.sum_after", sum, m_sum);
        cyc(0, 0, 1, 32'hDEAD);
        cyc(0, 0, 0, 0);

        // Gaps in in_valid.
        cyc(1, 2, 0, 0);
        cyc(0, 0, 1, 32'h11);
        cyc(0, 0, 0, 32'h99);
        cyc(0, 0, 0, 32'h98);
        cyc(0, 0, 1, 32'h22);
        cyc(0, 0, 0, 0);

        // Zero-length burst.
        cyc(1, 0, 1, 32'h55);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Start while loading is ignored.
        cyc(1, 2, 0, 0);
        cyc(1, 9, 1, 32'hA);
        cyc(1, 9, 0, 0);
        cyc(1, 9, 1, 32'hB);
        cyc(1, 9, 1, 32'hC);
        cyc(0, 0, 0, 0);

        // Sum wraps mod 2^32.
        cyc(1, 2, 0, 0);
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        cyc(0, 0, 1, 32'h2);
        cyc(0, 0, 0, 0);
`ifdef CHECKSUM_EN
        chk("t6.sum_wrap", sum, 32'h1);
`else
        chk("t6.sum_off", sum, 32'h0);
`endif

        // Reset mid-burst after 2 of 4 words, then restart at address 0.
        done_pulses = 0;
        cyc(1, 4, 0, 0);
        cyc(0, 0, 1, 32'h100);
        cyc(0, 0, 1, 32'h200);
        async_reset();
        cyc(0, 0, 1, 32'h300);
        chk("t1.no_done", 32'(done_pulses), 32'd0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 32'h400);
        chk("t1.restart_addr", mem_addr, 32'h0);
        cyc(0, 0, 0, 0);

        // Randomized bursts with random gaps and spurious starts.
        for (int b = 0; b < 12; b++) begin
            cyc(1, 30'($urandom_range(0, 6)), 0, 0);
            guard = 0;
            while ((m_loading || m_finish) && guard < 60) begin
                cyc($urandom_range(0, 3) == 0, 30'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0, $urandom);
                guard++;
            end
            chk("rand.burst_bound", 32'(m_loading || m_finish), 32'd0);
            cyc(0, 0, $urandom_range(0, 1), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
